// File: rtl/rand_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rand_sampler : filters an LFSR byte stream (dedup + bound) into a FIFO and |
// |                flags a stuck source.   Revision: 1.0                       |
// +----------------------------------------------------------------------------+
module rand_sampler #(
   parameter int DEPTH     = 4,
   parameter int STUCK_MAX = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   rnd_in,
   input  logic                         en,
   input  logic [7:0]                   limit,
   input  logic                         clr_err,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [7:0]                   out_data,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         stuck_err
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_LW = $clog2(DEPTH+1);
   localparam logic [c_LW-1:0] c_FULL  = c_LW'(DEPTH);
   localparam logic [7:0]      c_STUCK = 8'(STUCK_MAX);

   logic [7:0]      r_mem [DEPTH];
   logic [c_AW-1:0] r_wptr;
   logic [c_AW-1:0] r_rptr;
   logic [c_LW-1:0] r_level;
   logic [7:0]      r_prev;
   logic            r_prev_vld;
   logic [7:0]      r_run;
   logic            r_stuck;

   logic            w_dup;
   logic            w_accept;
   logic            w_pop;
   logic            w_push;
   logic [7:0]      w_run_nxt;
   logic            w_stuck_set;

   assign w_dup    = r_prev_vld && (rnd_in == r_prev);
   assign w_accept = en && !w_dup && ((limit == 8'd0) || (rnd_in < limit));
   assign w_pop    = out_valid && out_ready;
   // A full FIFO still takes a sample when the head leaves in the same cycle.
   assign w_push   = w_accept && ((r_level != c_FULL) || w_pop);

   assign w_run_nxt   = !w_dup ? 8'd1 :
                        (r_run == c_STUCK) ? r_run : r_run + 8'd1;
   assign w_stuck_set = (w_run_nxt == c_STUCK);

   assign out_valid = (r_level != '0);
   // Gating with level keeps out_data at zero under reset without clearing the array.
   assign out_data  = out_valid ? r_mem[r_rptr] : 8'h00;
   assign level     = r_level;
   assign stuck_err = r_stuck;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= rnd_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_prev     <= 8'h00;
         r_prev_vld <= 1'b0;
         r_run      <= 8'd0;
         r_stuck    <= 1'b0;
      end else begin
         r_prev     <= rnd_in;
         r_prev_vld <= 1'b1;
         r_run      <= w_run_nxt;
         r_stuck    <= w_stuck_set | (r_stuck & ~clr_err);
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rand_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rand_sampler : scoreboard bench for rand_sampler (DEPTH=4, STUCK_MAX=8) |
// |                   Revision: 1.0                                            |
// +----------------------------------------------------------------------------+
module tb_rand_sampler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rnd_in;
   logic       en;
   logic [7:0] limit;
   logic       clr_err;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] level;
   logic       stuck_err;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } ent_t;

   ent_t sb[$];
   ent_t obs[$];
   int   cycle = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   rand_sampler #(.DEPTH(4), .STUCK_MAX(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .rnd_in    (rnd_in),
      .en        (en),
      .limit     (limit),
      .clr_err   (clr_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .stuck_err (stuck_err)
   );

   // Called at a falling edge; drives one cycle, logs handshakes, queues expectations.
   task automatic tick(input logic [7:0] r, input logic e, input logic [7:0] lim,
                       input logic rdy, input logic clr, input bit exp_acc, input bit chk_lat);
      ent_t x;
      rnd_in = r; en = e; limit = lim; out_ready = rdy; clr_err = clr;
      #1;
      if (out_valid && out_ready) begin
         x.data = out_data; x.cyc = cycle;
         obs.push_back(x);
      end
      if (exp_acc) begin
         x.data = r; x.cyc = chk_lat ? cycle + 1 : -1;
         sb.push_back(x);
      end
      @(posedge clk);
      @(negedge clk);
      cycle++;
   endtask

   // Idle values alternate F0/F1 so idling never builds a duplicate run.
   task automatic idle(input logic rdy);
      tick(8'hF0 | 8'(cycle & 1), 1'b0, 8'h00, rdy, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1; rnd_in = 8'h00; en = 1'b0; limit = 8'h00; out_ready = 1'b0; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h required 00", out_data); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d required 0", level); end
      n_cmp++; if (stuck_err !== 1'b0) begin n_err++; $display("FAIL reset_stuck: got %b required 0", stuck_err); end
      rst = 1'b0;
      idle(1'b1); idle(1'b1);
   endtask

   task automatic test_basic;
      logic [7:0] v [6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
      ent_t e, o;
      for (int i = 0; i < 6; i++) tick(v[i], 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 16 && level != 0; k++) idle(1'b1);
      idle(1'b1);
      n_cmp++; if (obs.size() !== sb.size()) begin n_err++; $display("FAIL basic_count: got %0d required %0d", obs.size(), sb.size()); end
      while (sb.size() > 0 && obs.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_cmp++;
         if (o.data !== e.data || o.cyc != e.cyc) begin
            n_err++; $display("FAIL basic_data: got %h@%0d required %h@%0d", o.data, o.cyc, e.data, e.cyc);
         end
      end
      sb.delete(); obs.delete();
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL basic_level: got %0d required 0", level); end
   endtask

   task automatic test_limit;
      logic [7:0] v [8] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'h30, 8'h2F};
      bit         a [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      ent_t e, o;
      for (int i = 0; i < 8; i++) tick(v[i], 1'b1, 8'h30, 1'b1, 1'b0, a[i], 1'b1);
      for (int k = 0; k < 16 && level != 0; k++) idle(1'b1);
      idle(1'b1);
      n_cmp++; if (obs.size() !== sb.size()) begin n_err++; $display("FAIL limit_count: got %0d required %0d", obs.size(), sb.size()); end
      while (sb.size() > 0 && obs.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_cmp++;
         if (o.data !== e.data || o.cyc != e.cyc) begin
            n_err++; $display("FAIL limit_data: got %h@%0d required %h@%0d", o.data, o.cyc, e.data, e.cyc);
         end
      end
      sb.delete(); obs.delete();
   endtask

   task automatic test_full;
      logic [7:0] v [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      ent_t e, o;
      for (int i = 0; i < 6; i++) tick(v[i], 1'b1, 8'h00, 1'b0, 1'b0, i < 4, 1'b0);
      idle(1'b0);
      n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d required 4", level); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin
         n_err++; $display("FAIL full_head: got %b/%h required 1/11", out_valid, out_data);
      end
      for (int k = 0; k < 16 && level != 0; k++) idle(1'b1);
      idle(1'b1);
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL full_drain_level: got %0d required 0", level); end
      n_cmp++; if (obs.size() !== sb.size()) begin n_err++; $display("FAIL full_count: got %0d required %0d", obs.size(), sb.size()); end
      while (sb.size() > 0 && obs.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_cmp++;
         if (o.data !== e.data) begin n_err++; $display("FAIL full_data: got %h required %h", o.data, e.data); end
      end
      sb.delete(); obs.delete();
   endtask

   task automatic test_back_to_back;
      ent_t e, o;
      for (int i = 0; i < 4; i++) tick(8'hA1 + 8'(i), 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick(8'hB1 + 8'(i), 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
         n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL b2b_level: got %0d required 4 (step %0d)", level, i); end
      end
      for (int k = 0; k < 16 && level != 0; k++) idle(1'b1);
      idle(1'b1);
      n_cmp++; if (obs.size() !== sb.size()) begin n_err++; $display("FAIL b2b_count: got %0d required %0d", obs.size(), sb.size()); end
      while (sb.size() > 0 && obs.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_cmp++;
         if (o.data !== e.data) begin n_err++; $display("FAIL b2b_data: got %h required %h", o.data, e.data); end
      end
      sb.delete(); obs.delete();
   endtask

   task automatic test_stuck;
      ent_t e, o;
      for (int i = 0; i < 8; i++) begin
         tick(8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, i == 0, 1'b0);
         if (i == 6) begin
            n_cmp++; if (stuck_err !== 1'b0) begin n_err++; $display("FAIL stuck_early: got %b required 0", stuck_err); end
         end
      end
      n_cmp++; if (stuck_err !== 1'b1) begin n_err++; $display("FAIL stuck_set: got %b required 1", stuck_err); end
      tick(8'h5A, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (stuck_err !== 1'b1) begin n_err++; $display("FAIL stuck_set_wins: got %b required 1", stuck_err); end
      tick(8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (stuck_err !== 1'b0) begin n_err++; $display("FAIL stuck_clear: got %b required 0", stuck_err); end
      for (int k = 0; k < 16 && level != 0; k++) idle(1'b1);
      idle(1'b1);
      n_cmp++; if (obs.size() !== sb.size()) begin n_err++; $display("FAIL stuck_count: got %0d required %0d", obs.size(), sb.size()); end
      while (sb.size() > 0 && obs.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_cmp++;
         if (o.data !== e.data) begin n_err++; $display("FAIL stuck_data: got %h required %h", o.data, e.data); end
      end
      sb.delete(); obs.delete();
   endtask

   task automatic test_reset_mid;
      ent_t e, o;
      for (int i = 0; i < 3; i++) tick(8'hC1 + 8'(i), 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL mid_prelevel: got %0d required 3", level); end
      rnd_in = 8'h77; en = 1'b1;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 8'h00) begin
         n_err++; $display("FAIL mid_async: got %b/%0d/%h required 0/0/00", out_valid, level, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      tick(8'h77, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 16 && level != 0; k++) idle(1'b1);
      idle(1'b1);
      n_cmp++; if (obs.size() !== sb.size()) begin n_err++; $display("FAIL mid_count: got %0d required %0d", obs.size(), sb.size()); end
      while (sb.size() > 0 && obs.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_cmp++;
         if (o.data !== e.data || o.cyc != e.cyc) begin
            n_err++; $display("FAIL mid_data: got %h@%0d required %h@%0d", o.data, o.cyc, e.data, e.cyc);
         end
      end
      sb.delete(); obs.delete();
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_basic;
      test_limit;
      test_full;
      test_back_to_back;
      test_stuck;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
